// File: rtl/cv32e40p_illegal_insn_tracker.sv
// Illegal-instruction event capture: dedups stalled repeats, queues {pc, instr, hart} in a FIFO.
// Optional timestamping via `define CV32E40P_ILLEGAL_INSN_TIMESTAMP_EN.
module cv32e40p_illegal_insn_tracker #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned TS_WIDTH  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 is_decoding_i,
    input  logic                 illegal_insn_dec_i,
    input  logic [31:0]          pc_id_i,
    input  logic [31:0]          instr_rdata_id_i,
    input  logic [31:0]          hart_id_i,
    output logic                 evt_valid_o,
    input  logic                 evt_ready_i,
    output logic [31:0]          evt_pc_o,
    output logic [31:0]          evt_instr_o,
    output logic [3:0]           evt_hart_o,
`ifdef CV32E40P_ILLEGAL_INSN_TIMESTAMP_EN
    output logic [TS_WIDTH-1:0]  evt_ts_o,
`endif
    output logic [CNT_WIDTH-1:0] illegal_cnt_o,
    output logic [CNT_WIDTH-1:0] drop_cnt_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OccW = $clog2(DEPTH + 1);

    logic                 last_det_q;
    logic [31:0]          last_pc_q;
    logic [PtrW-1:0]      wptr_q, rptr_q;
    logic [OccW-1:0]      occ_q;
    logic [CNT_WIDTH-1:0] illegal_cnt_q, drop_cnt_q;
    logic [31:0]          mem_pc_q    [DEPTH];
    logic [31:0]          mem_instr_q [DEPTH];
    logic [3:0]           mem_hart_q  [DEPTH];

    logic det, new_evt, not_empty, pop, push, drop;
    logic unused_hart_bits;

    assign unused_hart_bits = ^hart_id_i[31:4];

    assign det       = is_decoding_i & illegal_insn_dec_i;
    assign new_evt   = det & ~(last_det_q & (pc_id_i == last_pc_q));
    assign not_empty = (occ_q != '0);
    assign pop       = not_empty & evt_ready_i;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push      = new_evt & ((occ_q < OccW'(DEPTH)) | pop);
    assign drop      = new_evt & ~push;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_det_q <= 1'b0;
            last_pc_q  <= '0;
        end else begin
            last_det_q <= det & ~clear_i;
            if (det) begin
                last_pc_q <= pc_id_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else if (clear_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (push && !pop) begin
                occ_q <= occ_q + 1'b1;
            end else if (pop && !push) begin
                occ_q <= occ_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_pc_q[i]    <= '0;
                mem_instr_q[i] <= '0;
                mem_hart_q[i]  <= '0;
            end
        end else if (push && !clear_i) begin
            mem_pc_q[wptr_q]    <= pc_id_i;
            mem_instr_q[wptr_q] <= instr_rdata_id_i;
            mem_hart_q[wptr_q]  <= hart_id_i[3:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            illegal_cnt_q <= '0;
            drop_cnt_q    <= '0;
        end else if (clear_i) begin
            illegal_cnt_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            if (new_evt && (illegal_cnt_q != '1)) begin
                illegal_cnt_q <= illegal_cnt_q + 1'b1;
            end
            if (drop && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

`ifdef CV32E40P_ILLEGAL_INSN_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q;
    logic [TS_WIDTH-1:0] mem_ts_q [DEPTH];

    // Free-running; deliberately unaffected by clear_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_ts_q[i] <= '0;
            end
        end else if (push && !clear_i) begin
            mem_ts_q[wptr_q] <= ts_q;
        end
    end

    assign evt_ts_o = not_empty ? mem_ts_q[rptr_q] : '0;
`else
    localparam int unsigned unused_ts_width = TS_WIDTH;
`endif

    assign evt_valid_o   = not_empty;
    assign evt_pc_o      = not_empty ? mem_pc_q[rptr_q]    : '0;
    assign evt_instr_o   = not_empty ? mem_instr_q[rptr_q] : '0;
    assign evt_hart_o    = not_empty ? mem_hart_q[rptr_q]  : '0;
    assign illegal_cnt_o = illegal_cnt_q;
    assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_cv32e40p_illegal_insn_tracker.sv
// Directed bench for cv32e40p_illegal_insn_tracker; a second instance with CNT_WIDTH=2
// shares the stimulus to exercise counter saturation.
module tb_cv32e40p_illegal_insn_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        is_decoding;
    logic        illegal;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] hart;
    logic        ready;

    logic        valid, s_valid;
    logic [31:0] e_pc, e_instr, s_pc, s_instr;
    logic [3:0]  e_hart, s_hart;
    logic [15:0] ill_cnt, drp_cnt;
    logic [1:0]  s_ill_cnt, s_drp_cnt;
`ifdef CV32E40P_ILLEGAL_INSN_TIMESTAMP_EN
    logic [31:0] e_ts, s_ts;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cv32e40p_illegal_insn_tracker dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .clear_i            (clear),
        .is_decoding_i      (is_decoding),
        .illegal_insn_dec_i (illegal),
        .pc_id_i            (pc),
        .instr_rdata_id_i   (instr),
        .hart_id_i          (hart),
        .evt_valid_o        (valid),
        .evt_ready_i        (ready),
        .evt_pc_o           (e_pc),
        .evt_instr_o        (e_instr),
        .evt_hart_o         (e_hart),
`ifdef CV32E40P_ILLEGAL_INSN_TIMESTAMP_EN
        .evt_ts_o           (e_ts),
`endif
        .illegal_cnt_o      (ill_cnt),
        .drop_cnt_o         (drp_cnt)
    );

    cv32e40p_illegal_insn_tracker #(.CNT_WIDTH(2)) dut_sat (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .clear_i            (clear),
        .is_decoding_i      (is_decoding),
        .illegal_insn_dec_i (illegal),
        .pc_id_i            (pc),
        .instr_rdata_id_i   (instr),
        .hart_id_i          (hart),
        .evt_valid_o        (s_valid),
        .evt_ready_i        (ready),
        .evt_pc_o           (s_pc),
        .evt_instr_o        (s_instr),
        .evt_hart_o         (s_hart),
`ifdef CV32E40P_ILLEGAL_INSN_TIMESTAMP_EN
        .evt_ts_o           (s_ts),
`endif
        .illegal_cnt_o      (s_ill_cnt),
        .drop_cnt_o         (s_drp_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_det(input logic d, input logic [31:0] p);
        is_decoding = d;
        illegal     = d;
        pc          = p;
        instr       = p ^ 32'hA5A5_0000;
        hart        = 32'h0000_0010 | (p[7:4] & 4'hF);
    endtask

    task automatic do_clear();
        set_det(1'b0, 32'h0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        ready = 1'b0;
        set_det(1'b0, 32'h0);
        #12;
        check("rst_valid", {31'b0, valid}, 32'h0);
        check("rst_pc", e_pc, 32'h0);
        check("rst_ill_cnt", {16'b0, ill_cnt}, 32'h0);
        check("rst_drp_cnt", {16'b0, drp_cnt}, 32'h0);
        rst_n = 1'b1;
        tick();

        // 1: single illegal instruction
        is_decoding = 1'b1;
        illegal     = 1'b1;
        pc          = 32'h0000_0100;
        instr       = 32'hFFFF_FFFF;
        hart        = 32'h0000_0013;
        tick();
        set_det(1'b0, 32'h0);
        check("t1_valid", {31'b0, valid}, 32'h1);
        check("t1_pc", e_pc, 32'h100);
        check("t1_instr", e_instr, 32'hFFFF_FFFF);
        check("t1_hart", {28'b0, e_hart}, 32'h3);
        check("t1_cnt", {16'b0, ill_cnt}, 32'h1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("t1_popped", {31'b0, valid}, 32'h0);
        check("t1_pc_zero", e_pc, 32'h0);

        // 2: stalled repeat is deduplicated; a gap re-arms
        do_clear();
        set_det(1'b1, 32'h200);
        for (int i = 0; i < 5; i++) tick();
        check("t2_once", {16'b0, ill_cnt}, 32'h1);
        check("t2_head", e_pc, 32'h200);
        set_det(1'b0, 32'h200);
        tick();
        set_det(1'b1, 32'h200);
        tick();
        set_det(1'b0, 32'h0);
        check("t2_again", {16'b0, ill_cnt}, 32'h2);

        // 3: overflow with DEPTH=4, then drain
        do_clear();
        for (int i = 1; i <= 6; i++) begin
            set_det(1'b1, 32'h10 * i);
            tick();
        end
        set_det(1'b0, 32'h0);
        check("t3_ill", {16'b0, ill_cnt}, 32'h6);
        check("t3_drop", {16'b0, drp_cnt}, 32'h2);
        tick();
        check("t3_hold_pc", e_pc, 32'h10);
        check("t3_hold_instr", e_instr, 32'h10 ^ 32'hA5A5_0000);
        ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("t3_valid", {31'b0, valid}, 32'h1);
            check("t3_order", e_pc, 32'h10 * i);
            tick();
        end
        check("t3_empty", {31'b0, valid}, 32'h0);
        ready = 1'b0;

        // 4: full FIFO with pop and push together
        foreach (pc[i]) begin end
        set_det(1'b1, 32'hA0); tick();
        set_det(1'b1, 32'hB0); tick();
        set_det(1'b1, 32'hC0); tick();
        set_det(1'b1, 32'hD0); tick();
        ready = 1'b1;
        set_det(1'b1, 32'h80);
        tick();
        set_det(1'b0, 32'h0);
        check("t4_nodrop", {16'b0, drp_cnt}, 32'h2);
        check("t4_ill", {16'b0, ill_cnt}, 32'd11);
        check("t4_head_B0", e_pc, 32'hB0);
        tick();
        check("t4_head_C0", e_pc, 32'hC0);
        tick();
        check("t4_head_D0", e_pc, 32'hD0);
        tick();
        check("t4_tail_80", e_pc, 32'h80);
        tick();
        check("t4_empty", {31'b0, valid}, 32'h0);
        ready = 1'b0;

        // 5: clear overrides a same-cycle event; held instruction re-records
        do_clear();
        set_det(1'b1, 32'h304); tick();
        set_det(1'b1, 32'h308); tick();
        set_det(1'b1, 32'h30C); tick();
        set_det(1'b1, 32'h300);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t5_clr_valid", {31'b0, valid}, 32'h0);
        check("t5_clr_ill", {16'b0, ill_cnt}, 32'h0);
        check("t5_clr_drop", {16'b0, drp_cnt}, 32'h0);
        tick();
        set_det(1'b0, 32'h0);
        check("t5_new_valid", {31'b0, valid}, 32'h1);
        check("t5_new_pc", e_pc, 32'h300);
        check("t5_new_cnt", {16'b0, ill_cnt}, 32'h1);

        // 6: saturation on the 2-bit instance, then async reset mid-drain
        do_clear();
        for (int i = 0; i < 5; i++) begin
            set_det(1'b1, 32'h400 + 32'h10 * i);
            tick();
        end
        set_det(1'b0, 32'h0);
        check("t6_sat_ill", {30'b0, s_ill_cnt}, 32'h3);
        check("t6_sat_drop", {30'b0, s_drp_cnt}, 32'h1);
        check("t6_wide_ill", {16'b0, ill_cnt}, 32'h5);
        ready = 1'b1;
        tick();
        check("t6_drain_pc", e_pc, 32'h410);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", {31'b0, valid}, 32'h0);
        check("t6_rst_pc", e_pc, 32'h0);
        check("t6_rst_ill", {16'b0, ill_cnt}, 32'h0);
        check("t6_rst_drop", {16'b0, drp_cnt}, 32'h0);
        check("t6_rst_sat", {30'b0, s_ill_cnt}, 32'h0);
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
